// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: AXI4-Stream UART transmitter with runtime frame format.
// Frame = start, 5..DATA_WIDTH data bits LSB first, optional even/odd
// parity, one or two stop bits. Bit period T = max(prescale,1)*8 clocks.
module uart_tx_cfg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  txd,
    output logic                  busy,
    input  logic [15:0]           prescale,
    input  logic [4:0]            data_bits,
    input  logic [1:0]            parity_mode,
    input  logic                  stop2
);

    localparam logic [4:0] MAX_BITS = 5'(DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state;
    logic [18:0]           pcnt;      // cycles left in current bit
    logic [18:0]           tper;      // latched T-1
    logic [4:0]            bit_cnt;   // data bits / extra stop bits remaining
    logic [4:0]            nbits;     // latched, clamped data bit count
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_en;
    logic                  par_odd;
    logic                  par_acc;   // running XOR of bits already sent
    logic                  stop2_r;

    logic [15:0] ps_eff;
    logic [18:0] tper_in;
    logic [4:0]  nbits_in;
    logic        hs;
    logic        bit_end;

    // Clamp incoming configuration into the values latched at handshake
    always_comb begin
        ps_eff   = (prescale == 16'd0) ? 16'd1 : prescale;
        tper_in  = {ps_eff, 3'b000} - 19'd1;
        nbits_in = data_bits;
        if (data_bits < 5'd5)
            nbits_in = 5'd5;
        else if (data_bits > MAX_BITS)
            nbits_in = MAX_BITS;
        hs      = s_axis_tready & s_axis_tvalid;
        bit_end = (pcnt == 19'd0);
    end

    // Frame sequencer; every output is registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            txd           <= 1'b1;
            busy          <= 1'b0;
            s_axis_tready <= 1'b0;
            pcnt          <= '0;
            tper          <= '0;
            bit_cnt       <= '0;
            nbits         <= '0;
            shreg         <= '0;
            par_en        <= 1'b0;
            par_odd       <= 1'b0;
            par_acc       <= 1'b0;
            stop2_r       <= 1'b0;
        end else if (hs) begin
            // Handshake in IDLE or on the last stop cycle: start bit now
            shreg         <= s_axis_tdata;
            nbits         <= nbits_in;
            tper          <= tper_in;
            pcnt          <= tper_in;
            par_en        <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
            par_odd       <= (parity_mode == 2'b10);
            stop2_r       <= stop2;
            txd           <= 1'b0;
            busy          <= 1'b1;
            s_axis_tready <= 1'b0;
            state         <= START;
        end else if (state == IDLE) begin
            s_axis_tready <= 1'b1;
            busy          <= 1'b0;
            txd           <= 1'b1;
        end else if (!bit_end) begin
            pcnt <= pcnt - 19'd1;
            // Raise tready one cycle early so a waiting word follows with no gap
            if (state == STOP && bit_cnt == 5'd0 && pcnt == 19'd1)
                s_axis_tready <= 1'b1;
        end else begin
            pcnt <= tper;
            case (state)
                START: begin
                    txd     <= shreg[0];
                    par_acc <= shreg[0];
                    shreg   <= shreg >> 1;
                    bit_cnt <= nbits - 5'd1;
                    state   <= DATA;
                end
                DATA: begin
                    if (bit_cnt != 5'd0) begin
                        txd     <= shreg[0];
                        par_acc <= par_acc ^ shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt - 5'd1;
                    end else if (par_en) begin
                        txd   <= par_acc ^ par_odd;
                        state <= PARITY;
                    end else begin
                        txd     <= 1'b1;
                        bit_cnt <= {4'b0, stop2_r};
                        state   <= STOP;
                    end
                end
                PARITY: begin
                    txd     <= 1'b1;
                    bit_cnt <= {4'b0, stop2_r};
                    state   <= STOP;
                end
                STOP: begin
                    if (bit_cnt != 5'd0) begin
                        bit_cnt <= bit_cnt - 5'd1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        txd   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: every frame is compared cycle by cycle
// against a hand-computed bit vector (bit 0 = start bit).
module tb_uart_tx_cfg;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        txd;
    logic        busy;
    logic [15:0] prescale;
    logic [4:0]  data_bits;
    logic [1:0]  parity_mode;
    logic        stop2;

    int errors = 0;
    int checks = 0;

    uart_tx_cfg #(.DATA_WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .txd           (txd),
        .busy          (busy),
        .prescale      (prescale),
        .data_bits     (data_bits),
        .parity_mode   (parity_mode),
        .stop2         (stop2)
    );

    always #5 clk = ~clk;

    // Advance one clock; sample/drive 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for tready, present a word, handshake on the next edge
    task automatic send(input logic [7:0] d);
        int n = 0;
        while (!s_axis_tready && n < 1000) begin
            step();
            n++;
        end
        chk("tready_wait", {31'b0, s_axis_tready}, 32'd1);
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
    endtask

    // Called just after the handshake edge; checks every cycle of the frame
    task automatic check_frame(input string name, input logic [15:0] exp, input int n, input int t);
        for (int c = 0; c < n * t; c++) begin
            chk($sformatf("%s txd c%0d", name, c), {31'b0, txd}, {31'b0, exp[c / t]});
            chk($sformatf("%s busy c%0d", name, c), {31'b0, busy}, 32'd1);
            chk($sformatf("%s tready c%0d", name, c), {31'b0, s_axis_tready},
                (c == n * t - 1) ? 32'd1 : 32'd0);
            step();
        end
    endtask

    task automatic idle_check(input string name);
        chk({name, " idle busy"}, {31'b0, busy}, 32'd0);
        chk({name, " idle tready"}, {31'b0, s_axis_tready}, 32'd1);
        chk({name, " idle txd"}, {31'b0, txd}, 32'd1);
    endtask

    initial begin
        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'h00;
        prescale      = 16'd1;
        data_bits     = 5'd8;
        parity_mode   = 2'b00;
        stop2         = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst tready", {31'b0, s_axis_tready}, 32'd0);
        chk("rst txd", {31'b0, txd}, 32'd1);
        chk("rst busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        step();
        chk("first tready", {31'b0, s_axis_tready}, 32'd1);
        chk("first busy", {31'b0, busy}, 32'd0);

        // 8N1, 0x55: 0,1,0,1,0,1,0,1,0,1
        send(8'h55);
        check_frame("8n1_55", 16'h02AA, 10, 8);
        idle_check("8n1_55");

        // 0x07 even parity -> parity bit 1
        parity_mode = 2'b01;
        send(8'h07);
        check_frame("even_07", 16'h060E, 11, 8);
        idle_check("even_07");

        // 0x07 odd parity -> parity bit 0
        parity_mode = 2'b10;
        send(8'h07);
        check_frame("odd_07", 16'h040E, 11, 8);
        idle_check("odd_07");

        // Mode 11 behaves as no parity
        parity_mode = 2'b11;
        send(8'h07);
        check_frame("par11_07", 16'h020E, 10, 8);
        idle_check("par11_07");

        // 7 data bits, two stops, 0xFF: 10-bit frame
        parity_mode = 2'b00;
        data_bits   = 5'd7;
        stop2       = 1'b1;
        send(8'hFF);
        check_frame("7n2_ff", 16'h03FE, 10, 8);
        idle_check("7n2_ff");

        // data_bits=3 clamps to 5: five zero data bits before the stop
        data_bits = 5'd3;
        stop2     = 1'b0;
        send(8'h00);
        check_frame("clamp_lo", 16'h0040, 7, 8);
        idle_check("clamp_lo");

        // data_bits=31 clamps to 8
        data_bits = 5'd31;
        send(8'h00);
        check_frame("clamp_hi", 16'h0200, 10, 8);
        idle_check("clamp_hi");
        data_bits = 5'd8;

        // Back-to-back with tvalid held: 0xA5 then 0x3C, no gap
        s_axis_tdata  = 8'hA5;
        s_axis_tvalid = 1'b1;
        step();
        s_axis_tdata  = 8'h3C;
        check_frame("b2b_a5", 16'h034A, 10, 8);
        s_axis_tvalid = 1'b0;
        check_frame("b2b_3c", 16'h0278, 10, 8);
        idle_check("b2b_3c");

        // Config change mid-frame only affects the next frame
        send(8'h0F);
        prescale    = 16'd4;
        parity_mode = 2'b01;
        check_frame("mid_0f", 16'h021E, 10, 8);
        idle_check("mid_0f");
        send(8'h01);
        prescale    = 16'd1;
        parity_mode = 2'b00;
        check_frame("next_01", 16'h0602, 11, 32);
        idle_check("next_01");

        // prescale=0 treated as 1
        prescale = 16'd0;
        send(8'h55);
        check_frame("ps0_55", 16'h02AA, 10, 8);
        idle_check("ps0_55");
        prescale = 16'd1;

        // Reset during data bit 3 (frame cycle 34)
        send(8'h55);
        repeat (34) step();
        rst = 1'b1;
        step();
        chk("mrst txd", {31'b0, txd}, 32'd1);
        chk("mrst busy", {31'b0, busy}, 32'd0);
        chk("mrst tready", {31'b0, s_axis_tready}, 32'd0);
        rst = 1'b0;
        step();
        chk("mrst tready_up", {31'b0, s_axis_tready}, 32'd1);
        chk("mrst txd_idle", {31'b0, txd}, 32'd1);
        send(8'h3C);
        check_frame("post_rst_3c", 16'h0278, 10, 8);
        idle_check("post_rst_3c");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
